// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and source encoding for the stage-2 register-file writeback path.
package cpu_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 1 << ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requesters, decode scoreboard query and the register-file write port.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int ADDR_W   = cpu_pkg::ADDR_W,
   parameter int NUM_REGS = cpu_pkg::NUM_REGS
);
   logic                src0_valid;
   logic [ADDR_W-1:0]   src0_rd;
   logic [DATA_W-1:0]   src0_data;
   logic                src0_ready;
   logic                src1_valid;
   logic [ADDR_W-1:0]   src1_rd;
   logic [DATA_W-1:0]   src1_data;
   logic                src1_ready;
   logic                reserve_en;
   logic [ADDR_W-1:0]   reserve_rd;
   logic [ADDR_W-1:0]   rs1;
   logic [ADDR_W-1:0]   rs2;
   logic                hazard;
   logic                write_en;
   logic [ADDR_W-1:0]   write_select;
   logic [DATA_W-1:0]   write_data;
   logic [NUM_REGS-1:0] pending;

   modport master (
      output src0_valid, src0_rd, src0_data, src1_valid, src1_rd, src1_data,
      output reserve_en, reserve_rd, rs1, rs2,
      input  src0_ready, src1_ready, hazard, write_en, write_select, write_data, pending
   );

   modport slave (
      input  src0_valid, src0_rd, src0_data, src1_valid, src1_rd, src1_data,
      input  reserve_en, reserve_rd, rs1, rs2,
      output src0_ready, src1_ready, hazard, write_en, write_select, write_data, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner.
module rr_arbiter2
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   src_e r_last;

   // On contention the source that did not win last time is granted.
   always_comb begin
      o_gnt = 2'b00;
      if (i_req[SRC_ALU] && (!i_req[SRC_LSU] || r_last == SRC_LSU)) begin
         o_gnt[SRC_ALU] = 1'b1;
      end else if (i_req[SRC_LSU]) begin
         o_gnt[SRC_LSU] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= SRC_LSU;
      end else if (o_gnt[SRC_ALU]) begin
         r_last <= SRC_ALU;
      end else if (o_gnt[SRC_LSU]) begin
         r_last <= SRC_LSU;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register-file write port, with a RAW pending scoreboard.
module regfile_wb_arbiter
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   regfile_wb_arbiter_if.slave bus
);

   logic [1:0]          w_req;
   logic [1:0]          w_gnt;
   logic                w_gnt_any;
   logic [ADDR_W-1:0]   w_gnt_rd;
   logic [DATA_W-1:0]   w_gnt_data;
   logic                w_wr;
   logic [NUM_REGS-1:0] w_pending_nxt;

   logic                r_write_en;
   logic [ADDR_W-1:0]   r_write_select;
   logic [DATA_W-1:0]   r_write_data;
   logic [NUM_REGS-1:0] r_pending;

   assign w_req[SRC_ALU] = bus.src0_valid;
   assign w_req[SRC_LSU] = bus.src1_valid;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req),
      .o_gnt (w_gnt)
   );

   assign bus.src0_ready = w_gnt[SRC_ALU];
   assign bus.src1_ready = w_gnt[SRC_LSU];

   assign w_gnt_any  = |w_gnt;
   assign w_gnt_rd   = w_gnt[SRC_LSU] ? bus.src1_rd   : bus.src0_rd;
   assign w_gnt_data = w_gnt[SRC_LSU] ? bus.src1_data : bus.src0_data;
   // x0 writes are accepted from the source but never reach the register file.
   assign w_wr       = w_gnt_any && (w_gnt_rd != REG_ZERO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_en     <= 1'b0;
         r_write_select <= '0;
         r_write_data   <= '0;
      end else begin
         r_write_en <= w_wr;
         if (w_wr) begin
            r_write_select <= w_gnt_rd;
            r_write_data   <= w_gnt_data;
         end
      end
   end

   // Set is applied after clear so a fresh reservation beats a same-cycle retirement.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_gnt_any) begin
         w_pending_nxt[w_gnt_rd] = 1'b0;
      end
      if (bus.reserve_en) begin
         w_pending_nxt[bus.reserve_rd] = 1'b1;
      end
      w_pending_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign bus.hazard       = r_pending[bus.rs1] | r_pending[bus.rs2];
   assign bus.pending      = r_pending;
   assign bus.write_en     = r_write_en;
   assign bus.write_select = r_write_select;
   assign bus.write_data   = r_write_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued by stimulus and popped by a monitor.
module tb_regfile_wb_arbiter;
   import cpu_pkg::*;

   logic clk;
   logic rst_n;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [ADDR_W-1:0] sel;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] data);
      wr_t w;
      w.sel  = sel;
      w.data = data;
      exp_q.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.src0_valid = 1'b0;
      bus.src1_valid = 1'b0;
      bus.reserve_en = 1'b0;
   endtask

   // Monitor: every register-file write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && bus.write_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_sel", {59'd0, bus.write_select}, 64'h1_0000_0000);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("write_select", {59'd0, bus.write_select}, {59'd0, w.sel});
            check("write_data",   {32'd0, bus.write_data},   {32'd0, w.data});
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.src0_valid = 1'b0;
      bus.src0_rd    = '0;
      bus.src0_data  = '0;
      bus.src1_valid = 1'b0;
      bus.src1_rd    = '0;
      bus.src1_data  = '0;
      bus.reserve_en = 1'b0;
      bus.reserve_rd = '0;
      bus.rs1        = 5'd3;
      bus.rs2        = 5'd7;

      // Power-on reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_write_en",  {63'd0, bus.write_en}, 64'd0);
      check("rst_pending",   {32'd0, bus.pending},  64'd0);
      check("rst_wsel",      {59'd0, bus.write_select}, 64'd0);
      check("rst_wdata",     {32'd0, bus.write_data},   64'd0);
      check("rst_hazard",    {63'd0, bus.hazard},   64'd0);
      rst_n = 1'b1;
      tick();

      // Single source, non-pending register
      bus.src0_valid = 1'b1;
      bus.src0_rd    = 5'd5;
      bus.src0_data  = 32'hDEADBEEF;
      #2;
      check("single_src0_ready", {63'd0, bus.src0_ready}, 64'd1);
      check("single_src1_ready", {63'd0, bus.src1_ready}, 64'd0);
      push_wr(5'd5, 32'hDEADBEEF);
      tick();
      idle_inputs();
      check("single_pending", {32'd0, bus.pending}, 64'd0);
      tick();

      // Mid-cycle reset drops the in-flight write and clears the scoreboard
      bus.reserve_en = 1'b1;
      bus.reserve_rd = 5'd3;
      tick();
      bus.reserve_en = 1'b0;
      bus.src0_valid = 1'b1;
      bus.src0_rd    = 5'd6;
      bus.src0_data  = 32'h66;
      @(posedge clk);
      #1;
      bus.src0_valid = 1'b0;
      check("pre_rst_write_en", {63'd0, bus.write_en}, 64'd1);
      check("pre_rst_hazard",   {63'd0, bus.hazard},   64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_write_en", {63'd0, bus.write_en}, 64'd0);
      check("midrst_pending",  {32'd0, bus.pending},  64'd0);
      check("midrst_hazard",   {63'd0, bus.hazard},   64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Contention: pointer reset to LSU, so ALU wins first and grants alternate
      bus.src0_valid = 1'b1;
      bus.src0_rd    = 5'd1;
      bus.src0_data  = 32'h11;
      bus.src1_valid = 1'b1;
      bus.src1_rd    = 5'd2;
      bus.src1_data  = 32'h22;
      for (int k = 0; k < 4; k++) begin
         #2;
         check("cont_src0_ready", {63'd0, bus.src0_ready}, {63'd0, (k % 2 == 0)});
         check("cont_src1_ready", {63'd0, bus.src1_ready}, {63'd0, (k % 2 == 1)});
         if (k % 2 == 0) push_wr(5'd1, 32'h11);
         else            push_wr(5'd2, 32'h22);
         tick();
      end
      idle_inputs();
      tick();

      // Scoreboard hazard on rd=9
      bus.rs1        = 5'd9;
      bus.rs2        = 5'd0;
      bus.reserve_en = 1'b1;
      bus.reserve_rd = 5'd9;
      #2;
      check("hz_before_reserve", {63'd0, bus.hazard}, 64'd0);
      tick();
      bus.reserve_en = 1'b0;
      check("hz_after_reserve", {63'd0, bus.hazard}, 64'd1);
      check("pend_after_reserve", {32'd0, bus.pending}, 64'h200);
      bus.src1_valid = 1'b1;
      bus.src1_rd    = 5'd9;
      bus.src1_data  = 32'h99;
      #2;
      check("hz_grant_cycle", {63'd0, bus.hazard},     64'd1);
      check("hz_src1_ready",  {63'd0, bus.src1_ready}, 64'd1);
      push_wr(5'd9, 32'h99);
      tick();
      idle_inputs();
      check("hz_after_grant", {63'd0, bus.hazard},  64'd0);
      check("pend_cleared",   {32'd0, bus.pending}, 64'd0);

      // Set-wins on same-cycle reserve and clear of rd=4
      bus.reserve_en = 1'b1;
      bus.reserve_rd = 5'd4;
      tick();
      check("sw_pend_set", {32'd0, bus.pending}, 64'h10);
      bus.src0_valid = 1'b1;
      bus.src0_rd    = 5'd4;
      bus.src0_data  = 32'h44;
      #2;
      check("sw_src0_ready", {63'd0, bus.src0_ready}, 64'd1);
      push_wr(5'd4, 32'h44);
      tick();
      idle_inputs();
      check("sw_pend_kept", {32'd0, bus.pending}, 64'h10);
      bus.src1_valid = 1'b1;
      bus.src1_rd    = 5'd4;
      bus.src1_data  = 32'h45;
      push_wr(5'd4, 32'h45);
      tick();
      idle_inputs();
      check("sw_pend_retired", {32'd0, bus.pending}, 64'd0);
      tick();

      // x0: accepted but never written, never reserved
      bus.src1_valid = 1'b1;
      bus.src1_rd    = 5'd0;
      bus.src1_data  = 32'h55;
      bus.reserve_en = 1'b1;
      bus.reserve_rd = 5'd0;
      #2;
      check("x0_src1_ready", {63'd0, bus.src1_ready}, 64'd1);
      tick();
      idle_inputs();
      check("x0_write_en", {63'd0, bus.write_en},     64'd0);
      check("x0_pending",  {32'd0, bus.pending},      64'd0);
      check("x0_hold_sel", {59'd0, bus.write_select}, 64'd4);
      check("x0_hold_dat", {32'd0, bus.write_data},   64'h45);
      repeat (3) tick();

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
